// File: rtl/branch_resolve_ctrl_if.sv
// rtl/branch_resolve_ctrl_if.sv - decode-to-branch-controller bundle with decode/controller modports
interface branch_resolve_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             br_valid;
  logic             br_ready;
  logic             B;
  logic [7:0]       decoded_f3;
  logic [31:0]      rs1_data;
  logic [31:0]      rs2_data;
  logic [31:0]      pc;
  logic [31:0]      imm;
  logic             cnt_clr;
  logic [2:0]       comp_code;
  logic             res_valid;
  logic             taken;
  logic [31:0]      target_pc;
  logic             pc_sel;
  logic             flush;
  logic             stall;
  logic             illegal;
  logic             misalign;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] taken_count;

  // Decode side: presents branches, observes resolution and front-end control
  modport master (
    output br_valid, B, decoded_f3, rs1_data, rs2_data, pc, imm, cnt_clr,
    input  br_ready, comp_code, res_valid, taken, target_pc, pc_sel, flush,
           stall, illegal, misalign, branch_count, taken_count
  );

  // Controller side
  modport slave (
    input  br_valid, B, decoded_f3, rs1_data, rs2_data, pc, imm, cnt_clr,
    output br_ready, comp_code, res_valid, taken, target_pc, pc_sel, flush,
           stall, illegal, misalign, branch_count, taken_count
  );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// rtl/branch_resolve_ctrl.sv - multi-cycle RV32I branch resolution, redirect/flush sequencing and statistics
module branch_resolve_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  branch_resolve_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, EVAL, FLUSH} state_t;

  localparam logic [3:0]       FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [3:0]       fcnt_q, fcnt_d;
  logic [31:0]      rs1_q, rs2_q, pc_q, imm_q;
  logic [7:0]       f3_q;
  logic [31:0]      tgt_q;
  logic [2:0]       code_q;
  logic [CNT_W-1:0] bcnt_q, tcnt_q;

  logic        accept;
  logic        in_eval;
  logic        f3_legal;
  logic [2:0]  eval_code;
  logic        cond;
  logic        cond_taken;
  logic [31:0] eval_target;
  logic        misaligned;
  logic        redirect;

  assign accept  = (state_q == IDLE) && bus.br_valid && bus.B;
  assign in_eval = (state_q == EVAL);

  // Exactly one bit set, and not one of the two funct3 codes RV32I leaves unused
  assign f3_legal = (f3_q != 8'd0) && ((f3_q & (f3_q - 8'd1)) == 8'd0) && !f3_q[2] && !f3_q[3];

  // One-hot funct3 to comparator select; illegal encodings report 000
  always_comb begin
    eval_code = 3'b000;
    if (f3_legal) begin
      if (f3_q[1])      eval_code = 3'b001;
      else if (f3_q[4]) eval_code = 3'b100;
      else if (f3_q[5]) eval_code = 3'b101;
      else if (f3_q[6]) eval_code = 3'b110;
      else if (f3_q[7]) eval_code = 3'b111;
      else              eval_code = 3'b000;
    end
  end

  // Branch comparator driven by the selected comparison
  always_comb begin
    cond = 1'b0;
    case (eval_code)
      3'b000:  cond = (rs1_q == rs2_q);
      3'b001:  cond = (rs1_q != rs2_q);
      3'b100:  cond = ($signed(rs1_q) <  $signed(rs2_q));
      3'b101:  cond = ($signed(rs1_q) >= $signed(rs2_q));
      3'b110:  cond = (rs1_q <  rs2_q);
      3'b111:  cond = (rs1_q >= rs2_q);
      default: cond = 1'b0;
    endcase
  end

  assign cond_taken  = f3_legal && cond;
  assign eval_target = cond_taken ? (pc_q + imm_q) : (pc_q + 32'd4);
  assign misaligned  = cond_taken && (eval_target[1:0] != 2'b00);
  assign redirect    = cond_taken && !misaligned;

  // State and flush down-counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      fcnt_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Next-state: one EVAL cycle, then FLUSH only for an aligned taken redirect
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = EVAL;
      end
      EVAL: begin
        if (redirect) begin
          state_d = FLUSH;
          fcnt_d  = FLUSH_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      FLUSH: begin
        if (fcnt_q == 4'd0) state_d = IDLE;
        else                fcnt_d  = fcnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture the branch operands when decode hands one over
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs1_q <= 32'd0;
      rs2_q <= 32'd0;
      pc_q  <= 32'd0;
      imm_q <= 32'd0;
      f3_q  <= 8'd0;
    end else if (accept) begin
      rs1_q <= bus.rs1_data;
      rs2_q <= bus.rs2_data;
      pc_q  <= bus.pc;
      imm_q <= bus.imm;
      f3_q  <= bus.decoded_f3;
    end
  end

  // Hold the resolved target and select after EVAL so they stay stable through FLUSH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tgt_q  <= 32'd0;
      code_q <= 3'b000;
    end else if (in_eval) begin
      tgt_q  <= eval_target;
      code_q <= eval_code;
    end
  end

  // Saturating statistics; clear takes priority over a same-cycle increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt_q <= '0;
      tcnt_q <= '0;
    end else if (bus.cnt_clr) begin
      bcnt_q <= '0;
      tcnt_q <= '0;
    end else begin
      if (in_eval && f3_legal && (bcnt_q != CNT_MAX)) bcnt_q <= bcnt_q + CNT_ONE;
      if (in_eval && redirect && (tcnt_q != CNT_MAX)) tcnt_q <= tcnt_q + CNT_ONE;
    end
  end

  assign bus.br_ready     = (state_q == IDLE);
  assign bus.stall        = (state_q != IDLE);
  assign bus.res_valid    = in_eval;
  assign bus.comp_code    = in_eval ? eval_code : code_q;
  assign bus.target_pc    = in_eval ? eval_target : tgt_q;
  assign bus.taken        = in_eval && cond_taken;
  assign bus.illegal      = in_eval && !f3_legal;
  assign bus.misalign     = in_eval && misaligned;
  assign bus.flush        = (state_q == FLUSH);
  assign bus.pc_sel       = (state_q == FLUSH);
  assign bus.branch_count = bcnt_q;
  assign bus.taken_count  = tcnt_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb/tb_branch_resolve_ctrl.sv - scoreboard bench for branch_resolve_ctrl
module tb_branch_resolve_ctrl;

  localparam int FC = 2;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct {
    logic [2:0]  code;
    logic        tk;
    logic [31:0] tgt;
    logic        ill;
    logic        mis;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_resolve_ctrl_if #(.CNT_W(CW)) bus();

  branch_resolve_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t sb_q[$];
  exp_t mon_e;
  int   vectors     = 0;
  int   miscompares = 0;
  int   exp_bcnt    = 0;
  int   exp_tcnt    = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] f3, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] pc, input logic [31:0] imm);
    exp_t e;
    logic c;
    logic lg;
    lg = 1'b1;
    c  = 1'b0;
    e.code = 3'b000;
    case (f3)
      8'h01: begin e.code = 3'b000; c = (a == b); end
      8'h02: begin e.code = 3'b001; c = (a != b); end
      8'h10: begin e.code = 3'b100; c = ($signed(a) <  $signed(b)); end
      8'h20: begin e.code = 3'b101; c = ($signed(a) >= $signed(b)); end
      8'h40: begin e.code = 3'b110; c = (a <  b); end
      8'h80: begin e.code = 3'b111; c = (a >= b); end
      default: lg = 1'b0;
    endcase
    e.ill = !lg;
    e.tk  = lg && c;
    e.tgt = e.tk ? (pc + imm) : (pc + 32'd4);
    e.mis = e.tk && (e.tgt[1:0] != 2'b00);
    return e;
  endfunction

  // Resolution monitor: every res_valid strobe pops one scoreboard entry
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.res_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_val("unexpected_res", sb_q.size(), 1);
      end else begin
        mon_e = sb_q.pop_front();
        check_val("comp_code", bus.comp_code, mon_e.code);
        check_val("taken",     bus.taken,     mon_e.tk);
        check_val("target_pc", bus.target_pc, mon_e.tgt);
        check_val("illegal",   bus.illegal,   mon_e.ill);
        check_val("misalign",  bus.misalign,  mon_e.mis);
        check_val("eval_flush", bus.flush,    0);
        check_val("eval_stall", bus.stall,    1);
      end
    end
  end

  task automatic run_branch(input string tag, input logic [7:0] f3, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] pc, input logic [31:0] imm,
                            input logic clr);
    exp_t e;
    int   waited;
    int   fl;
    e = model(f3, a, b, pc, imm);
    waited = 0;
    @(negedge clk);
    while (bus.br_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) check_val({tag, "_ready_timeout"}, bus.br_ready, 1);
    bus.br_valid   = 1'b1;
    bus.B          = 1'b1;
    bus.decoded_f3 = f3;
    bus.rs1_data   = a;
    bus.rs2_data   = b;
    bus.pc         = pc;
    bus.imm        = imm;
    bus.cnt_clr    = clr;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    bus.br_valid = 1'b0;
    bus.B        = 1'b0;
    @(posedge clk);
    #1;
    bus.cnt_clr = 1'b0;
    if (clr) begin
      exp_bcnt = 0;
      exp_tcnt = 0;
    end else if (!e.ill) begin
      if (exp_bcnt < CMAX) exp_bcnt++;
      if (e.tk && !e.mis && exp_tcnt < CMAX) exp_tcnt++;
    end
    fl = 0;
    @(negedge clk);
    while (bus.flush === 1'b1 && fl < 40) begin
      check_val({tag, "_pc_sel"},     bus.pc_sel,    1);
      check_val({tag, "_hold_tgt"},   bus.target_pc, e.tgt);
      check_val({tag, "_fl_stall"},   bus.stall,     1);
      fl++;
      @(negedge clk);
    end
    check_val({tag, "_flush_len"}, fl, (e.tk && !e.mis) ? FC : 0);
    check_val({tag, "_ready"},     bus.br_ready,     1);
    check_val({tag, "_bcnt"},      bus.branch_count, exp_bcnt);
    check_val({tag, "_tcnt"},      bus.taken_count,  exp_tcnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, %0d vectors applied", vectors);
    $fatal(1);
  end

  initial begin
    logic [7:0] legal_f3 [6];
    legal_f3 = '{8'h01, 8'h02, 8'h10, 8'h20, 8'h40, 8'h80};

    rst            = 1'b1;
    bus.br_valid   = 1'b0;
    bus.B          = 1'b0;
    bus.decoded_f3 = 8'h00;
    bus.rs1_data   = 32'd0;
    bus.rs2_data   = 32'd0;
    bus.pc         = 32'd0;
    bus.imm        = 32'd0;
    bus.cnt_clr    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_ready",  bus.br_ready,     1);
    check_val("rst_stall",  bus.stall,        0);
    check_val("rst_flush",  bus.flush,        0);
    check_val("rst_pcsel",  bus.pc_sel,       0);
    check_val("rst_resv",   bus.res_valid,    0);
    check_val("rst_code",   bus.comp_code,    0);
    check_val("rst_tgt",    bus.target_pc,    0);
    check_val("rst_bcnt",   bus.branch_count, 0);
    check_val("rst_tcnt",   bus.taken_count,  0);
    @(negedge clk);
    rst = 1'b0;

    // Reset arriving in the first FLUSH cycle
    @(negedge clk);
    bus.br_valid   = 1'b1;
    bus.B          = 1'b1;
    bus.decoded_f3 = 8'h01;
    bus.rs1_data   = 32'd5;
    bus.rs2_data   = 32'd5;
    bus.pc         = 32'h100;
    bus.imm        = 32'h20;
    sb_q.push_back(model(8'h01, 32'd5, 32'd5, 32'h100, 32'h20));
    @(posedge clk);
    #1;
    bus.br_valid = 1'b0;
    bus.B        = 1'b0;
    @(posedge clk);
    #2;
    check_val("pre_rst_flush", bus.flush, 1);
    rst = 1'b1;
    #1;
    check_val("midrst_flush", bus.flush,        0);
    check_val("midrst_pcsel", bus.pc_sel,       0);
    check_val("midrst_ready", bus.br_ready,     1);
    check_val("midrst_bcnt",  bus.branch_count, 0);
    check_val("midrst_tcnt",  bus.taken_count,  0);
    check_val("midrst_tgt",   bus.target_pc,    0);
    @(negedge clk);
    rst = 1'b0;
    exp_bcnt = 0;
    exp_tcnt = 0;

    run_branch("beq_taken", 8'h01, 32'd7, 32'd7, 32'h100, 32'h40, 1'b0);
    run_branch("blt",  8'h10, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h10, 1'b0);
    run_branch("bltu", 8'h40, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h10, 1'b0);
    run_branch("ill04", 8'h04, 32'd3, 32'd3, 32'h300, 32'h8, 1'b0);
    run_branch("ill03", 8'h03, 32'd3, 32'd3, 32'h300, 32'h8, 1'b0);
    run_branch("ill00", 8'h00, 32'd3, 32'd3, 32'h300, 32'h8, 1'b0);
    run_branch("bne_wrap", 8'h02, 32'd1, 32'd2, 32'hFFFF_FFF0, 32'h20, 1'b0);
    run_branch("bne_mis",  8'h02, 32'd1, 32'd2, 32'hFFFF_FFF0, 32'h22, 1'b0);

    for (int i = 0; i < 12; i++) begin
      run_branch("rand", legal_f3[$urandom_range(0, 5)],
                 $urandom_range(0, 3) == 0 ? 32'h8000_0000 : 32'($urandom_range(0, 7)),
                 32'($urandom_range(0, 7)),
                 {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
                 {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, 1'b0);
    end

    for (int i = 0; i < 16; i++) begin
      run_branch("sat", 8'h01, 32'(i), 32'(i), 32'h1000, 32'h8, 1'b0);
    end
    check_val("sat_bcnt", bus.branch_count, CMAX);
    check_val("sat_tcnt", bus.taken_count,  CMAX);

    run_branch("clr", 8'h80, 32'd9, 32'd2, 32'h400, 32'h40, 1'b1);

    // Non-branch from decode is ignored
    @(negedge clk);
    bus.br_valid = 1'b1;
    bus.B        = 1'b0;
    @(posedge clk);
    #1;
    check_val("nob_stall", bus.stall,    0);
    check_val("nob_ready", bus.br_ready, 1);
    bus.br_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_val("nob_idle",  bus.br_ready,     1);
    check_val("nob_bcnt",  bus.branch_count, exp_bcnt);
    check_val("sb_empty",  sb_q.size(),      0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
